// File: rtl/keypad_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emu_pkg
//  Purpose  : Shared types, key code constants and key-map helpers for the
//             3x4 matrix keypad emulator.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_emu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int NUM_KEYS = 12;

  // Row-major map: row = code/3, col = code%3
  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_4    = 4'd3;
  localparam logic [3:0] KEY_5    = 4'd4;
  localparam logic [3:0] KEY_6    = 4'd5;
  localparam logic [3:0] KEY_7    = 4'd6;
  localparam logic [3:0] KEY_8    = 4'd7;
  localparam logic [3:0] KEY_9    = 4'd8;
  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_0    = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    return 2'(code / 4'd3);
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return 2'(code % 4'd3);
  endfunction

  function automatic logic [3:0] row_onehot(input logic [3:0] code);
    return 4'b0001 << key_row(code);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_emu_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emu_fifo
//  Purpose  : Small first-in first-out queue of pending key press requests.
//             Show-ahead read: dout_o always presents the head entry.
//             Simultaneous push and pop keep the occupancy unchanged.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_emu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_emu.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emu
//  Purpose  : Emulates a 3x4 matrix keypad. Queued key codes are "pressed"
//             for HOLD_CYCLES clocks each, separated by GAP_CYCLES released
//             clocks; while pressed, the row line of the active key follows
//             the scanner's strobe on that key's column one clock later.
//  Options  : define KEYPAD_EMU_BOUNCE_EN to add deterministic contact bounce
//             over the first 8 clocks of every press.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_emu
  import keypad_emu_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000,
  parameter int GAP_CYCLES  = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       err_code
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]  active_q;
  logic [3:0]  row_q;
  logic        err_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  fifo_dout;
  logic        accept;
  logic        code_ok;
  logic        push;
  logic        pop;
  logic        press_visible;

  assign key_ready = !fifo_full;
  assign accept    = key_valid && key_ready;
  assign code_ok   = (key_code < 4'(NUM_KEYS));
  assign push      = accept && code_ok;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;

  assign row       = row_q;
  assign err_code  = err_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  keypad_emu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .din_i   (key_code),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef KEYPAD_EMU_BOUNCE_EN
  // Clocks elapsed in the current press, saturating once bounce is over.
  logic [3:0] age_q;

  // Bounce: visible only on even elapsed counts during the first 8 clocks.
  assign press_visible = age_q[3] || !age_q[0];

  // Press age tracker, restarted on every pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= '0;
    end else if (pop) begin
      age_q <= '0;
    end else if (state_q == ST_PRESS && age_q != 4'd8) begin
      age_q <= age_q + 4'd1;
    end
  end
`else
  assign press_visible = 1'b1;
`endif

  // Press sequencer with registered row and error-pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      active_q <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && !code_ok;
      case (state_q)
        ST_IDLE: begin
          row_q <= '0;
          if (!fifo_empty) begin
            active_q <= fifo_dout;
            cnt_q    <= CW'(HOLD_CYCLES - 1);
            state_q  <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          // Only the active key's column matters; other strobes are ignored.
          row_q <= (col[key_col(active_q)] && press_visible) ? row_onehot(active_q) : 4'b0000;
          if (cnt_q == '0) begin
            cnt_q   <= CW'(GAP_CYCLES - 1);
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_GAP: begin
          row_q <= '0;
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          row_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_emu
//  Purpose  : Self-checking bench for keypad_emu. A timeline model (queue of
//             pending codes plus "clocks since pop") predicts row, busy,
//             key_ready, err_code and queue occupancy every clock.
//  Options  : honours KEYPAD_EMU_BOUNCE_EN the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_emu;

  localparam int HOLD  = 10;
  localparam int GAP   = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [2:0] col = 3'b000;
  logic       key_ready;
  logic [3:0] row;
  logic       busy;
  logic       err_code;

  always #5 clk = ~clk;

  keypad_emu #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .busy      (busy),
    .err_code  (err_code)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending codes, active key, clocks since its pop (-1 idle).
  int         mq[$];
  int         akey = 0;
  int         ph = -1;
  logic [3:0] e_row = 4'd0;
  logic       e_err = 1'b0;

  function automatic bit visible(input int e);
`ifdef KEYPAD_EMU_BOUNCE_EN
    return (e >= 8) || (e % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit acc;
    if (!reset) begin
      mq.delete();
      ph    = -1;
      e_row = 4'd0;
      e_err = 1'b0;
      return;
    end
    if (ph >= 0 && ph < HOLD && col[akey % 3] && visible(ph))
      e_row = 4'(1 << (akey / 3));
    else
      e_row = 4'd0;
    acc   = key_valid && (mq.size() < DEPTH);
    e_err = acc && (key_code >= 4'd12);
    if (ph < 0) begin
      if (mq.size() > 0) begin
        akey = mq.pop_front();
        ph   = 0;
      end
    end else begin
      ph++;
      if (ph == HOLD + GAP) ph = -1;
    end
    if (acc && key_code < 4'd12) mq.push_back(int'(key_code));
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("row", 8'(row), 8'(e_row));
    chk("busy", 8'(busy), 8'((ph != -1) || (mq.size() != 0)));
    chk("key_ready", 8'(key_ready), 8'(mq.size() < DEPTH));
    chk("err_code", 8'(err_code), 8'(e_err));
    chk("occupancy", 8'(dut.u_fifo.count_q), 8'(mq.size()));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && (ph != -1 || mq.size() != 0); i++) tick();
    chk("idle_reached", 8'(busy), 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_ready", 8'(key_ready), 8'd1);

    // First request accepted on the first edge after release
    reset = 1'b1;
    col   = 3'b001;
    push(4'd3);
    wait_idle();

    // Single press of '5' with a rotating column strobe
    col = 3'b001;
    push(4'd4);
    for (int i = 0; i < 24; i++) begin
      col = 3'(1 << (i % 3));
      tick();
    end
    wait_idle();

    // Overflow: six back-to-back requests with all columns strobed
    col = 3'b111;
    for (int i = 0; i < 6; i++) begin
      key_valid = 1'b1;
      key_code  = 4'($urandom_range(0, 11));
      tick();
    end
    key_valid = 1'b0;
    chk("overflow_full_ready", 8'(key_ready), 8'd0);
    wait_idle();

    // Invalid code: error pulse only
    push(4'd13);
    chk("invalid_err", 8'(err_code), 8'd1);
    tick();
    chk("invalid_err_drop", 8'(err_code), 8'd0);
    chk("invalid_busy", 8'(busy), 8'd0);

    // Simultaneous push and pop with three entries queued
    col = 3'b111;
    push(4'd1);
    push(4'd5);
    push(4'd7);
    push(4'd11);
    for (int i = 0; i < 100 && !(ph == -1 && mq.size() == 3); i++) tick();
    chk("occ3_reached", 8'(dut.u_fifo.count_q), 8'd3);
    push(4'd9);
    chk("occ3_kept", 8'(dut.u_fifo.count_q), 8'd3);
    chk("occ3_ready", 8'(key_ready), 8'd1);
    wait_idle();

    // Bounce-sensitive press: code 0 with column 0 held
    col = 3'b001;
    push(4'd0);
    wait_idle();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom_range(0, 15));
      col       = 3'($urandom_range(0, 7));
      tick();
    end
    key_valid = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a press of '0'
    col = 3'b010;
    push(4'd10);
    for (int i = 0; i < 20 && ph != 3; i++) tick();
    push(4'd2);
    #2;
    reset = 1'b0;
    #1;
    model_edge();
    check_all();
    chk("mid_reset_row", 8'(row), 8'd0);
    tick();
    reset = 1'b1;
    col   = 3'b001;
    push(4'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("after_reset_row", 8'(row), 8'b0001);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
- REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000: clocks a key stays pressed.
- REQ-002 The block SHALL have parameter GAP_CYCLES, default 50000: released clocks between queued presses.
- REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two: number of queued press requests.
- REQ-004 The block SHALL have port `clk`, input, 1 bit: the single system clock; all logic on the rising edge.
- REQ-005 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
- REQ-006 The block SHALL have port `key_valid`, input, 1 bit: a press request is offered.
- REQ-007 The block SHALL have port `key_code`, input, 4 bits: the key index, 0..11.
- REQ-008 The block SHALL have port `key_ready`, output, 1 bit: a request can be accepted.
- REQ-009 The block SHALL have port `col`, input, 3 bits: column strobes from the keypad scanner, active-high.
- REQ-010 The block SHALL have port `row`, output, 4 bits: row return lines to the scanner, active-high.
- REQ-011 The block SHALL have port `busy`, output, 1 bit: a press or gap is in progress, or the FIFO is non-empty.
- REQ-012 The block SHALL have port `err_code`, output, 1 bit: one-clock pulse when an invalid code is accepted.

Function
- REQ-013 Key map SHALL be row-major, row = code/3 and col = code%3:
  - codes 0..8 = digits 1..9;
  - code 9 = '*', code 10 = '0', code 11 = '#'.
- REQ-014 A request SHALL be accepted on a clock edge where key_valid=1 and key_ready=1.
- REQ-015 key_ready SHALL be the inverse of FIFO full.
  - key_valid while key_ready=0 is ignored; no state change.
- REQ-016 An accepted code of 12..15 SHALL NOT be queued.
  - err_code pulses high the next cycle.
- REQ-017 The FSM SHALL have states IDLE, PRESS and GAP.
- REQ-018 IDLE SHALL move to PRESS when the FIFO is non-empty.
  - The head entry is popped and latched as the active key.
  - The hold counter is loaded with HOLD_CYCLES-1.
- REQ-019 PRESS SHALL decrement the hold counter each cycle.
  - At 0 the FSM enters GAP and loads the counter with GAP_CYCLES-1.
- REQ-020 GAP SHALL decrement the counter each cycle and return to IDLE at 0.
- REQ-021 In PRESS, row[r] SHALL be registered high the cycle after col[c]=1, where (r,c) is the active key.
  - All other row bits are 0.
- REQ-022 Row output latency SHALL be exactly 1 clock after a col change.
- REQ-023 row SHALL be 0 in IDLE and GAP, and whenever the active key's column bit is 0.
- REQ-024 Multiple col bits set: row SHALL follow only the active key's column bit.
- REQ-025 Push and pop in the same cycle SHALL be legal.
  - The occupancy count stays unchanged.
  - FIFO order is strictly first-in first-out.
- REQ-026 busy SHALL be 0 only in IDLE with an empty FIFO.

Reset
- REQ-027 reset=0 SHALL asynchronously force the following, including mid-press:
  - FSM to IDLE and counters to 0;
  - FIFO empty;
  - row=0, err_code=0, busy=0, key_ready=1.
- REQ-028 After reset release, the first request SHALL be accepted on the first clock edge.

Configuration
- REQ-029 Macro KEYPAD_EMU_BOUNCE_EN, when defined, SHALL enable deterministic contact-bounce emulation.
  - During the first 8 cycles of PRESS, the press is visible only on cycles where the elapsed PRESS count is even.
  - Thereafter it is steady.
- REQ-030 Without KEYPAD_EMU_BOUNCE_EN, the press SHALL be steady for the whole PRESS state.

Structure
- REQ-031 Package keypad_emu_pkg SHALL hold:
  - the state enum;
  - key code constants KEY_1..KEY_9, KEY_STAR, KEY_0, KEY_HASH;
  - NUM_KEYS=12;
  - the code-to-row/col lookup functions.
- REQ-032 The queue SHALL be a sub-module keypad_emu_fifo, parameterised by FIFO_DEPTH and data width 4.

Verification
- REQ-033 Single press, HOLD=10, GAP=5, code 4 ('5'), col cycles 001/010/100:
  - row=0010 exactly one clock after each col=010, for 10 cycles;
  - row=0 otherwise;
  - busy drops 15 cycles after the pop.
- REQ-034 Overflow, DEPTH=4: push 6 codes back-to-back while idle with col=111.
  - key_ready falls after the 4th push when the first is not yet popped (or the 5th push if the pop overlaps).
  - Extra requests are ignored.
  - Queued keys replay in order.
- REQ-035 Invalid code: push 13.
  - err_code pulses 1 cycle.
  - busy stays 0; row stays 0.
- REQ-036 Reset mid-PRESS (code 10, col=010) at cycle 3:
  - row=0 immediately;
  - FIFO empty; key_ready=1;
  - a new code 0 is accepted and pressed afterwards.
- REQ-037 With KEYPAD_EMU_BOUNCE_EN, code 0, col=001 held:
  - row[0] pattern 1,0,1,0,1,0,1,0 then steady 1.
- REQ-038 Simultaneous push and pop with the FIFO at 3 entries SHALL leave occupancy at 3 and key_ready=1.
